// File: rtl/mips_run_ctrl_if.sv
// Board-side control bus of the run/step/breakpoint sequencer.
// master = board top (switches, core PC); slave = mips_run_ctrl.
interface mips_run_ctrl_if;
  logic        iRun;
  logic        iStep;
  logic        iClrCount;
  logic [31:0] iPC;
  logic [31:0] iBkptAddr;
  logic        iBkptEn;
  logic        oCPUEn;
  logic [1:0]  oState;
  logic        oHalted;
  logic        oBkptHit;
  logic [31:0] oCycleCount;

  modport master (
    output iRun, iStep, iClrCount, iPC, iBkptAddr, iBkptEn,
    input  oCPUEn, oState, oHalted, oBkptHit, oCycleCount
  );

  modport slave (
    input  iRun, iStep, iClrCount, iPC, iBkptAddr, iBkptEn,
    output oCPUEn, oState, oHalted, oBkptHit, oCycleCount
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/step/breakpoint sequencer producing the core-wide clock enable.
// Define MIPS_RUN_CTRL_BKPT_EN to build the PC breakpoint logic.
module mips_run_ctrl #(
  parameter int STEP_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  mips_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);

  logic [SYNC_STAGES-1:0] run_sync, step_sync, vld_pipe;
  logic                   run_s, step_s, step_prev, step_armed, step_edge;
  logic                   bkpt_match;
  state_t                 state_q, state_nx;
  logic [CW-1:0]          cnt_q, cnt_nx;
  logic                   halted_q, cpu_en;
  logic [31:0]            cycle_q;

  // vld_pipe marks when the synchronizer tail holds a real sample rather
  // than reset fill, so a button held through reset never looks released.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      run_sync   <= '0;
      step_sync  <= '0;
      vld_pipe   <= '0;
      step_prev  <= 1'b0;
      step_armed <= 1'b0;
    end else begin
      run_sync  <= {run_sync[SYNC_STAGES-2:0], bus.iRun};
      step_sync <= {step_sync[SYNC_STAGES-2:0], bus.iStep};
      vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
      step_prev <= step_s;
      if (vld_pipe[SYNC_STAGES-1] && !step_s)
        step_armed <= 1'b1;
    end
  end

  assign run_s     = run_sync[SYNC_STAGES-1];
  assign step_s    = step_sync[SYNC_STAGES-1];
  assign step_edge = step_armed && step_s && !step_prev;

`ifdef MIPS_RUN_CTRL_BKPT_EN
  assign bkpt_match = bus.iBkptEn && (bus.iPC == bus.iBkptAddr);
`else
  logic unused_bkpt;
  assign bkpt_match  = 1'b0;
  assign unused_bkpt = ^{bus.iPC, bus.iBkptAddr, bus.iBkptEn};
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= S_HALT;
      cnt_q    <= '0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      halted_q <= (state_nx == S_HALT) || (state_nx == S_BREAK);
    end
  end

  // Step edges outside HALT/BREAK fall through unhandled, i.e. are dropped.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    cpu_en   = 1'b0;
    case (state_q)
      S_HALT: begin
        if (run_s) begin
          state_nx = S_RUN;
        end else if (step_edge) begin
          state_nx = S_STEP;
          cnt_nx   = STEP_LOAD;
        end
      end
      S_RUN: begin
        cpu_en = !bkpt_match;
        if (!run_s)          state_nx = S_HALT;
        else if (bkpt_match) state_nx = S_BREAK;
      end
      S_STEP: begin
        cpu_en = 1'b1;
        if (cnt_q == '0) state_nx = S_HALT;
        else             cnt_nx   = cnt_q - CW'(1);
      end
      S_BREAK: begin
        if (!run_s) begin
          state_nx = S_HALT;
        end else if (step_edge) begin
          state_nx = S_STEP;
          cnt_nx   = STEP_LOAD;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

`ifdef MIPS_RUN_CTRL_BKPT_EN
  logic hit_q;
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) hit_q <= 1'b0;
    else      hit_q <= (state_q == S_RUN) && (state_nx == S_BREAK);
  end
  assign bus.oBkptHit = hit_q;
`else
  assign bus.oBkptHit = 1'b0;
`endif

  // Clear wins over the increment of the same cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)               cycle_q <= '0;
    else if (bus.iClrCount) cycle_q <= '0;
    else if (cpu_en)        cycle_q <= cycle_q + 32'd1;
  end

  assign bus.oCPUEn      = cpu_en;
  assign bus.oState      = state_q;
  assign bus.oHalted     = halted_q;
  assign bus.oCycleCount = cycle_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: expectations queued at stimulus time,
// popped and compared on negedge samples of the DUT outputs.
module tb_mips_run_ctrl;
  localparam int STEP_N = 3;

  logic iCLK    = 1'b0;
  logic iRST    = 1'b1;
  logic pc_load = 1'b1;

  mips_run_ctrl_if bus();

  mips_run_ctrl #(.STEP_CYCLES(STEP_N), .SYNC_STAGES(2)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  // Core PC model: advances by one instruction on every enabled cycle.
  always @(posedge iCLK) begin
    if (pc_load)         bus.iPC <= 32'h0040_0000;
    else if (bus.oCPUEn) bus.iPC <= bus.iPC + 32'd4;
  end

  string       sb_tag[$];
  logic [31:0] sb_exp[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    if (sb_exp.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      tag = sb_tag.pop_front();
      exp = sb_exp.pop_front();
      n_vec++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] exp, input logic [31:0] obs);
    push(tag, exp);
    chk(obs);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int k;
    k = 0;
    while (bus.oState !== st && k < budget) begin
      @(negedge iCLK);
      k++;
    end
    expect_now(tag, 32'(st), 32'(bus.oState));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_sum;
    bus.iRun      = 1'b0;
    bus.iStep     = 1'b0;
    bus.iClrCount = 1'b0;
    bus.iBkptAddr = 32'h0040_0010;
    bus.iBkptEn   = 1'b0;

    // Reset values
    tick(2);
    expect_now("rst_state",  32'd0, 32'(bus.oState));
    expect_now("rst_cpuen",  32'd0, 32'(bus.oCPUEn));
    expect_now("rst_halted", 32'd1, 32'(bus.oHalted));
    expect_now("rst_hit",    32'd0, 32'(bus.oBkptHit));
    expect_now("rst_count",  32'd0, bus.oCycleCount);
    iRST = 1'b0;
    tick(3);
    expect_now("idle_state", 32'd0, 32'(bus.oState));
    expect_now("idle_count", 32'd0, bus.oCycleCount);

    // Free run: 10 cycles, then drop the switch (3 more cycles through sync + exit)
    bus.iRun = 1'b1;
    wait_state("run_enter", 2'd1, 8);
    expect_now("run_count0", 32'd0, bus.oCycleCount);
    tick(10);
    expect_now("run_count10", 32'd10, bus.oCycleCount);
    expect_now("run_halted",  32'd0,  32'(bus.oHalted));
    bus.iRun = 1'b0;
    wait_state("run_exit", 2'd0, 8);
    expect_now("run_exit_count", 32'd13, bus.oCycleCount);
    tick(5);
    expect_now("halt_frozen", 32'd13, bus.oCycleCount);
    expect_now("halt_cpuen",  32'd0,  32'(bus.oCPUEn));
    expect_now("halt_halted", 32'd1,  32'(bus.oHalted));

    bus.iClrCount = 1'b1;
    tick(1);
    bus.iClrCount = 1'b0;
    expect_now("clr_halt", 32'd0, bus.oCycleCount);

    // Single step of STEP_N cycles; a second pulse lands mid-step and is dropped
    for (int k = 1; k <= 8; k++) begin
      push($sformatf("step_state_%0d", k), (k >= 3 && k <= 5) ? 32'd2 : 32'd0);
      push($sformatf("step_count_%0d", k), (k <= 3) ? 32'd0 : ((k >= 6) ? 32'd3 : 32'(k - 3)));
    end
    bus.iStep = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge iCLK);
      chk(32'(bus.oState));
      chk(bus.oCycleCount);
      bus.iStep = (k == 2);
    end
    bus.iStep = 1'b0;

`ifdef MIPS_RUN_CTRL_BKPT_EN
    // Breakpoint at 0x00400010, then continue-by-step
    pc_load       = 1'b1;
    bus.iBkptEn   = 1'b1;
    bus.iClrCount = 1'b1;
    tick(1);
    pc_load       = 1'b0;
    bus.iClrCount = 1'b0;
    expect_now("bk_clr", 32'd0, bus.oCycleCount);
    bus.iRun = 1'b1;
    wait_state("bk_enter", 2'd3, 20);
    expect_now("bk_hit",    32'd1, 32'(bus.oBkptHit));
    expect_now("bk_cpuen",  32'd0, 32'(bus.oCPUEn));
    expect_now("bk_count",  32'd4, bus.oCycleCount);
    expect_now("bk_halted", 32'd1, 32'(bus.oHalted));
    tick(1);
    expect_now("bk_hit_pulse", 32'd0, 32'(bus.oBkptHit));
    expect_now("bk_hold",      32'd3, 32'(bus.oState));
    bus.iStep = 1'b1;
    tick(1);
    bus.iStep = 1'b0;
    wait_state("bk_step", 2'd2, 8);
    expect_now("bk_step_cpuen", 32'd1, 32'(bus.oCPUEn));
    tick(STEP_N);
    expect_now("bk_cont_halt",  32'd0, 32'(bus.oState));
    expect_now("bk_cont_count", 32'd4 + 32'(STEP_N), bus.oCycleCount);
    tick(1);
    expect_now("bk_cont_run", 32'd1, 32'(bus.oState));
    bus.iRun    = 1'b0;
    bus.iBkptEn = 1'b0;
    wait_state("bk_exit", 2'd0, 8);
`else
    // Without the feature a matching PC must not stop the core
    pc_load       = 1'b1;
    bus.iBkptEn   = 1'b1;
    bus.iClrCount = 1'b1;
    tick(1);
    pc_load       = 1'b0;
    bus.iClrCount = 1'b0;
    bus.iRun      = 1'b1;
    wait_state("nobk_enter", 2'd1, 8);
    tick(8);
    expect_now("nobk_state", 32'd1, 32'(bus.oState));
    expect_now("nobk_hit",   32'd0, 32'(bus.oBkptHit));
    expect_now("nobk_count", 32'd8, bus.oCycleCount);
    bus.iRun    = 1'b0;
    bus.iBkptEn = 1'b0;
    wait_state("nobk_exit", 2'd0, 8);
`endif

    // Step button held through reset must not step
    bus.iStep = 1'b1;
    iRST = 1'b1;
    tick(2);
    iRST = 1'b0;
    tick(10);
    expect_now("held_state", 32'd0, 32'(bus.oState));
    expect_now("held_count", 32'd0, bus.oCycleCount);
    bus.iStep = 1'b0;
    tick(6);
    expect_now("held_rel_state", 32'd0, 32'(bus.oState));
    expect_now("held_rel_count", 32'd0, bus.oCycleCount);

    // Counter wrap and clear-over-increment
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    expect_now("wrap_preload", 32'hFFFF_FFFF, bus.oCycleCount);
    @(negedge iCLK);
    bus.iRun = 1'b1;
    wait_state("wrap_run", 2'd1, 8);
    expect_now("wrap_pre", 32'hFFFF_FFFF, bus.oCycleCount);
    tick(1);
    expect_now("wrap_zero", 32'd0, bus.oCycleCount);
    bus.iClrCount = 1'b1;
    tick(1);
    bus.iClrCount = 1'b0;
    expect_now("clr_over_inc", 32'd0, bus.oCycleCount);
    tick(1);
    expect_now("after_clr", 32'd1, bus.oCycleCount);
    bus.iRun = 1'b0;
    wait_state("wrap_exit", 2'd0, 8);

    // Reset in the middle of a step
    bus.iStep = 1'b1;
    tick(1);
    bus.iStep = 1'b0;
    wait_state("mid_step", 2'd2, 8);
    tick(1);
    expect_now("mid_step_cpuen", 32'd1, 32'(bus.oCPUEn));
    iRST = 1'b1;
    #1;
    expect_now("mid_rst_cpuen", 32'd0, 32'(bus.oCPUEn));
    expect_now("mid_rst_state", 32'd0, 32'(bus.oState));
    @(negedge iCLK);
    iRST = 1'b0;
    en_sum = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge iCLK);
      en_sum += int'(bus.oCPUEn);
    end
    expect_now("mid_rst_residual", 32'd0, 32'(en_sum));
    expect_now("mid_rst_count",    32'd0, bus.oCycleCount);
    expect_now("mid_rst_halted",   32'd1, 32'(bus.oHalted));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
